// File: rtl/lmem_pkg.sv
// rtl/lmem_pkg.sv - shared constants and state type for the layer-0-to-layer-1 L-memory.
package lmem_pkg;

  localparam int P            = 26;
  localparam int NCYC         = 20;
  localparam int ADDRESSWIDTH = 5;
  localparam int RD_LAT       = 3;
  localparam int ITERW        = 5;
  localparam int Nb           = 16;
  localparam int Wt           = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Counter width that stays at least one bit for a modulus of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lmem_01_addr_cnt.sv
// rtl/lmem_01_addr_cnt.sv - up counter with enable, clear and terminal-count flag at N-1.
module lmem_01_addr_cnt #(
  parameter int N = 20,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(N - 1));

endmodule

// File: rtl/lmem_01_sched.sv
// rtl/lmem_01_sched.sv - write/read/feedback sequencer for the layer-0-to-layer-1 L-memory.
// LMEM01_EARLY_TERM_EN: syndrome_ok in the final DRAIN cycle ends the codeword early.
module lmem_01_sched #(
  parameter int ADDRESSWIDTH = lmem_pkg::ADDRESSWIDTH,
  parameter int NCYC         = lmem_pkg::NCYC,
  parameter int ITERW        = lmem_pkg::ITERW,
  parameter int RD_LAT       = lmem_pkg::RD_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ITERW-1:0]        max_iter,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    rd_ready,
  input  logic                    syndrome_ok,
  output logic                    wr_en_regout,
  output logic                    rd_en_regout,
  output logic [ADDRESSWIDTH-1:0] rd_address_regout,
  output logic                    feedback_en_regout,
  output logic                    busy,
  output logic                    done,
  output logic [ITERW-1:0]        iter_count
);
  import lmem_pkg::*;

  localparam int CW = cnt_width(NCYC);
  localparam int DW = cnt_width(RD_LAT);

  state_t                  state, state_n;
  logic [ITERW-1:0]        max_q, max_n, iter_n;
  logic [ADDRESSWIDTH-1:0] addr_n;
  logic                    wr_n, rd_n, fb_n, done_n, busy_n;
  logic                    beat_en, beat_clr, addr_en, addr_clr, drn_en, drn_clr;
  logic                    beat_tc, addr_tc, drn_tc;
  logic [CW-1:0]           unused_beat_cnt, rd_cnt;
  logic [DW-1:0]           unused_drn_cnt;
  logic [ITERW:0]          iter_inc;
  logic                    lim_hit, finish;

  lmem_01_addr_cnt #(.N(NCYC), .W(CW)) u_beat_cnt (
    .clk(clk), .rst(rst), .en(beat_en), .clr(beat_clr), .count(unused_beat_cnt), .tc(beat_tc)
  );
  lmem_01_addr_cnt #(.N(NCYC), .W(CW)) u_addr_cnt (
    .clk(clk), .rst(rst), .en(addr_en), .clr(addr_clr), .count(rd_cnt), .tc(addr_tc)
  );
  lmem_01_addr_cnt #(.N(RD_LAT), .W(DW)) u_drain_cnt (
    .clk(clk), .rst(rst), .en(drn_en), .clr(drn_clr), .count(unused_drn_cnt), .tc(drn_tc)
  );

  assign iter_inc = {1'b0, iter_count} + 1'b1;
  assign lim_hit  = (iter_inc >= {1'b0, max_q});

`ifdef LMEM01_EARLY_TERM_EN
  assign finish = lim_hit | syndrome_ok;
`else
  logic unused_syndrome;
  assign unused_syndrome = syndrome_ok;
  assign finish          = lim_hit;
`endif

  assign in_ready = (state == WRITE);

  always_comb begin
    state_n  = state;
    max_n    = max_q;
    iter_n   = iter_count;
    addr_n   = rd_address_regout;
    fb_n     = feedback_en_regout;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    done_n   = 1'b0;
    beat_en  = 1'b0;
    beat_clr = 1'b0;
    addr_en  = 1'b0;
    addr_clr = 1'b0;
    drn_en   = 1'b0;
    drn_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        fb_n = 1'b0;
        if (start) begin
          max_n    = (max_iter == '0) ? ITERW'(1) : max_iter;
          iter_n   = '0;
          beat_clr = 1'b1;
          addr_clr = 1'b1;
          drn_clr  = 1'b1;
          state_n  = WRITE;
        end
      end
      WRITE: begin
        if (in_valid) begin
          wr_n = 1'b1;
          if (beat_tc) begin
            beat_clr = 1'b1;
            addr_clr = 1'b1;
            state_n  = READ;
          end else begin
            beat_en = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_ready) begin
          rd_n   = 1'b1;
          addr_n = ADDRESSWIDTH'(rd_cnt);
          if (addr_tc) begin
            addr_clr = 1'b1;
            drn_clr  = 1'b1;
            state_n  = DRAIN;
          end else begin
            addr_en = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drn_tc) begin
          drn_clr = 1'b1;
          iter_n  = iter_inc[ITERW-1:0];
          if (finish) begin
            done_n  = 1'b1;
            fb_n    = 1'b0;
            state_n = IDLE;
          end else begin
            fb_n     = 1'b1;
            beat_clr = 1'b1;
            state_n  = WRITE;
          end
        end else begin
          drn_en = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      max_q              <= '0;
      iter_count         <= '0;
      rd_address_regout  <= '0;
      feedback_en_regout <= 1'b0;
      wr_en_regout       <= 1'b0;
      rd_en_regout       <= 1'b0;
      done               <= 1'b0;
      busy               <= 1'b0;
    end else begin
      state              <= state_n;
      max_q              <= max_n;
      iter_count         <= iter_n;
      rd_address_regout  <= addr_n;
      feedback_en_regout <= fb_n;
      wr_en_regout       <= wr_n;
      rd_en_regout       <= rd_n;
      done               <= done_n;
      busy               <= busy_n;
    end
  end

endmodule

// File: tb/tb_lmem_01_sched.sv
// tb/tb_lmem_01_sched.sv - directed bench with a phase-level reference model for lmem_01_sched.
module tb_lmem_01_sched;

  localparam int NCYC   = 20;
  localparam int RD_LAT = 3;
`ifdef LMEM01_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [4:0] max_iter = '0;
  logic       in_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       syndrome_ok = 1'b0;
  logic       in_ready, wr_en_regout, rd_en_regout, feedback_en_regout, busy, done;
  logic [4:0] rd_address_regout, iter_count;

  lmem_01_sched dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter),
    .in_valid(in_valid), .in_ready(in_ready), .rd_ready(rd_ready),
    .syndrome_ok(syndrome_ok), .wr_en_regout(wr_en_regout),
    .rd_en_regout(rd_en_regout), .rd_address_regout(rd_address_regout),
    .feedback_en_regout(feedback_en_regout), .busy(busy), .done(done),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: phase 0 idle, 1 collecting beats, 2 issuing reads, 3 draining.
  int m_phase = 0, m_beats = 0, m_addr = 0, m_drain = 0, m_max = 0;
  int e_wr = 0, e_rd = 0, e_addr = 0, e_fb = 0, e_busy = 0, e_done = 0, e_iter = 0;
  int st_start = 0, st_wr = 0, st_rd = 0, st_fb = 0, d_lat = 0, d_iter = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    cyc++;
    e_wr = 0; e_rd = 0; e_done = 0;
    if (!rst) begin
      m_phase = 0; e_addr = 0; e_fb = 0; e_iter = 0; m_max = 0;
    end else begin
      case (m_phase)
        0: begin
          e_fb = 0;
          if (start) begin
            m_max = (max_iter == 0) ? 1 : int'(max_iter);
            e_iter = 0; m_beats = 0; m_phase = 1;
            st_start = cyc; st_wr = 0; st_rd = 0; st_fb = 0;
          end
        end
        1: if (in_valid) begin
          e_wr = 1; m_beats++;
          if (m_beats == NCYC) begin m_phase = 2; m_addr = 0; end
        end
        2: if (rd_ready) begin
          e_rd = 1; e_addr = m_addr; m_addr++;
          if (m_addr == NCYC) begin m_phase = 3; m_drain = RD_LAT; end
        end
        default: begin
          m_drain--;
          if (m_drain == 0) begin
            e_iter++;
            if (e_iter >= m_max || (EARLY && syndrome_ok)) begin
              e_done = 1; e_fb = 0; m_phase = 0;
            end else begin
              e_fb = 1; m_phase = 1; m_beats = 0;
            end
          end
        end
      endcase
    end
    e_busy = (m_phase != 0) ? 1 : 0;
  endtask

  task automatic compare_all();
    chk("wr_en", wr_en_regout, e_wr);
    chk("rd_en", rd_en_regout, e_rd);
    if (e_rd != 0) chk("rd_address", rd_address_regout, e_addr);
    chk("feedback_en", feedback_en_regout, e_fb);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("iter_count", iter_count, e_iter);
    chk("in_ready", in_ready, (m_phase == 1) ? 1 : 0);
    if (wr_en_regout) st_wr++;
    if (rd_en_regout) st_rd++;
    if (feedback_en_regout) st_fb++;
    if (done) begin d_lat = cyc - st_start + 1; d_iter = int'(iter_count); end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic pulse_start(input int m);
    start = 1'b1; max_iter = 5'(m);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin got = 1; break; end
    end
    chk("done_within_budget", got, 1);
  endtask

  task automatic chk_run(input string tag, input int lat, input int iters, input int wr, input int rd, input int fb);
    chk({tag, "_done_latency"}, d_lat, lat);
    chk({tag, "_iter_count"}, d_iter, iters);
    chk({tag, "_wr_pulses"}, st_wr, wr);
    chk({tag, "_rd_pulses"}, st_rd, rd);
    chk({tag, "_fb_cycles"}, st_fb, fb);
  endtask

  initial begin
    @(negedge clk);
    tick(); tick();
    chk("reset_busy", busy, 0);
    chk("reset_iter", iter_count, 0);
    chk("reset_addr", rd_address_regout, 0);
    rst = 1'b1;
    tick();

    // single iteration, no stalls
    in_valid = 1'b1; rd_ready = 1'b1;
    pulse_start(1);
    wait_done(100);
    chk_run("iter1", 44, 1, 20, 20, 0);
    tick();

    // three iterations, feedback only in rounds 2 and 3
    pulse_start(3);
    wait_done(200);
    chk_run("iter3", 130, 3, 60, 60, 86);
    tick();

    // max_iter of zero behaves as one
    pulse_start(0);
    wait_done(100);
    chk_run("iter0", 44, 1, 20, 20, 0);
    tick();

    // read stall of five cycles when address 7 is due
    pulse_start(1);
    repeat (27) tick();
    rd_ready = 1'b0;
    repeat (5) tick();
    rd_ready = 1'b1;
    wait_done(100);
    chk_run("stall", 49, 1, 20, 20, 0);
    tick();

    // alternating in_valid, with an ignored start mid-run
    pulse_start(1);
    for (int k = 1; k <= 40; k++) begin
      in_valid = k[0];
      start = (k == 10);
      max_iter = (k == 10) ? 5'd7 : 5'd1;
      tick();
    end
    start = 1'b0; in_valid = 1'b1;
    wait_done(100);
    chk_run("toggle", 63, 1, 20, 20, 0);
    tick();

    // asynchronous reset while reading address 12
    pulse_start(2);
    repeat (32) tick();
    rst = 1'b0;
    #1;
    chk("async_rst_rd_en", rd_en_regout, 0);
    chk("async_rst_addr", rd_address_regout, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_wr_en", wr_en_regout, 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    pulse_start(1);
    wait_done(100);
    chk_run("after_rst", 44, 1, 20, 20, 0);
    tick();

    // syndrome_ok during the drain of iteration 2
    pulse_start(5);
    repeat (83) tick();
    syndrome_ok = 1'b1;
    repeat (3) tick();
    syndrome_ok = 1'b0;
    wait_done(300);
    chk("syn_done_latency", d_lat, EARLY ? 87 : 216);
    chk("syn_iter_count", d_iter, EARLY ? 2 : 5);
    tick(); tick();
    chk("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lmem_01_sched.md
# lmem_01_sched

Sequencer that drives the write/read/feedback control of the layer-0-to-layer-1 L-memory for one LDPC codeword, with P=26 rows per cycle and 20 address cycles per layer. It sits directly upstream of the L-memory, between the layer-0 processing unit (write beats) and the layer-1 processing unit (read consumer). It runs up to a programmed number of iterations and reports completion.

## Interface
Parameters:
- ADDRESSWIDTH, 5: L-memory read address width.
- NCYC, 20: address cycles per layer, i.e. ceil(Z/P) = ceil(511/26).
- ITERW, 5: width of the iteration count fields.
- RD_LAT, 3: cycles from rd_en_regout to valid read data at the layer-1 input (input register, array, output register).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a codeword when idle.
- max_iter  in  ITERW  iteration limit; sampled on accepted start; 0 is treated as 1.
- in_valid  in  1  layer-0 result beat available.
- in_ready  out  1  block accepts a layer-0 beat this cycle.
- rd_ready  in  1  layer-1 unit can accept a read beat.
- syndrome_ok  in  1  parity check passed; used only with LMEM01_EARLY_TERM_EN.
- wr_en_regout  out  1  L-memory write enable.
- rd_en_regout  out  1  L-memory read enable.
- rd_address_regout  out  ADDRESSWIDTH  L-memory read address.
- feedback_en_regout  out  1  high for every iteration after the first.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the codeword finishes.
- iter_count  out  ITERW  number of completed iterations; holds after done until the next start.

## Operation
- States: IDLE, WRITE, READ, DRAIN.
- IDLE: when start=1, latch max_iter, clear iter_count, and go to WRITE. feedback_en_regout=0.
- WRITE: in_ready=1. Each cycle with in_valid=1 is a beat: wr_en_regout=1 on the next cycle and the beat counter increments. After beat NCYC-1, go to READ with rd_address cleared.
- READ: in_ready=0. Each cycle with rd_ready=1 issues a read: rd_en_regout=1 and rd_address_regout=current address, then the address increments. If rd_ready=0, no read is issued, rd_en_regout=0, and the address holds. After address NCYC-1 is issued, go to DRAIN.
- DRAIN: wait RD_LAT cycles. Then increment iter_count. If iter_count+1 ≥ max_iter, pulse done and go to IDLE. Otherwise set feedback_en_regout=1 and go to WRITE.
- start while busy is ignored. in_valid outside WRITE is ignored and not counted.
- Beat and address counters are clog2(NCYC) wide and wrap to 0 only on a state change, never by overflow.

## Timing
- All outputs are registered except in_ready, which decodes the state directly.
- Reset values: every output 0; state IDLE; all counters 0.
- Reset asserted mid-operation clears everything immediately, with no completion of the layer in flight.
- Minimum iteration time with no stalls is NCYC + NCYC + RD_LAT = 43 cycles.
- Latency from start to first in_ready is 1 cycle.
- done is asserted the cycle after the last DRAIN cycle. busy falls in that same cycle.
- feedback_en_regout changes only on the DRAIN→WRITE transition and is cleared in IDLE. It is stable for a whole iteration.

## Configuration
- LMEM01_EARLY_TERM_EN defined:
  - syndrome_ok is sampled in the final DRAIN cycle; 1 forces done and IDLE regardless of max_iter.
  - iter_count still increments for that iteration.
- Undefined: syndrome_ok is ignored, and only max_iter terminates.

## Structure
- Shared package lmem_pkg:
  - state enum;
  - NCYC, ADDRESSWIDTH, RD_LAT, and P=26 constants;
  - Nb=16 and Wt=2 shared with the L-memory.
- One natural sub-module, lmem_01_addr_cnt: a counter with enable, clear, and terminal-count flag at NCYC-1, instantiated for both the beat counter and the read address counter.

## Test plan
- start with max_iter=1 and continuous in_valid/rd_ready → 20 wr_en pulses, then 20 rd_en pulses with addresses 0..19; done at cycle 44 after start; iter_count=1; feedback_en never 1.
- max_iter=3, no stalls → three write/read rounds; feedback_en=1 during rounds 2–3 only; iter_count=3 at done.
- rd_ready low for 5 cycles at address 7 → address 7 is held and no rd_en is issued; then addresses 7..19 follow; done is delayed by 5 cycles.
- in_valid toggling 1/0 in WRITE → exactly 20 wr_en pulses over 40 cycles; a second start mid-run is ignored.
- rst low during READ at address 12 → all outputs 0 immediately; a fresh start restarts at beat 0.
- With LMEM01_EARLY_TERM_EN, max_iter=5, syndrome_ok=1 in DRAIN of iteration 2 → done with iter_count=2. Without the macro, the same stimulus runs to iter_count=5.
